// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin arbiter/sequencer sharing one register among N requesters
// Build option: define SHARED_REG_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module shared_reg_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int OW    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset_async,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   wdata,
    output logic [N-1:0]         gnt,
    output logic                 ack,
    output logic [OW-1:0]        owner,
    output logic [WIDTH-1:0]     q,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      ptr_q, ptr_d;
    logic [WIDTH-1:0]   data_q, data_d;

    logic [OW-1:0]      cand;
    logic [OW-1:0]      sel_idx;
    logic               sel_vld;

    // Scan downward so the candidate closest to the pointer is the last (winning) hit;
    // OW-bit addition wraps naturally because N is a power of two.
    always_comb begin
        cand    = '0;
        sel_idx = '0;
        sel_vld = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = ptr_q + OW'(k);
            if (req[cand]) begin
                sel_idx = cand;
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        ack_d   = 1'b0;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << sel_idx;
                    owner_d = sel_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (req[owner_q]) begin
                    data_d  = wdata[owner_q*WIDTH +: WIDTH];
`ifdef SHARED_REG_ARB_FIXED_PRIO_EN
                    ptr_d   = '0;
`else
                    ptr_d   = owner_q + OW'(1);
`endif
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
        end
    end

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign busy  = busy_q;
    assign owner = owner_q;
    assign q     = data_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - directed table-driven bench for shared_reg_arbiter
module tb_shared_reg_arbiter;

    logic        clk = 1'b0;
    logic        reset_async = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  gnt;
    logic        ack;
    logic [1:0]  owner;
    logic [7:0]  q;
    logic        busy;

    int nerr = 0;
    int nchk = 0;

    shared_reg_arbiter #(.N(4), .WIDTH(8)) dut (
        .clk         (clk),
        .reset_async (reset_async),
        .req         (req),
        .wdata       (wdata),
        .gnt         (gnt),
        .ack         (ack),
        .owner       (owner),
        .q           (q),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wd;
        logic [3:0]  gnt;
        logic        ack;
        logic [1:0]  own;
        logic [7:0]  q;
        logic        busy;
    } vec_t;

    vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int idx, input logic [3:0] eg, input logic ea,
                           input logic [1:0] eo, input logic [7:0] eq, input logic eb);
        chk({nm, ".gnt"},   idx, 32'(gnt),   32'(eg));
        chk({nm, ".ack"},   idx, 32'(ack),   32'(ea));
        chk({nm, ".owner"}, idx, 32'(owner), 32'(eo));
        chk({nm, ".q"},     idx, 32'(q),     32'(eq));
        chk({nm, ".busy"},  idx, 32'(busy),  32'(eb));
    endtask

    initial begin
        int  gidx;
        int  acks;
        int  waited;
        int  expi;

        // single write, wrap from pointer 3, abort with pointer held at 1, then pointer=1 proof
        vecs[0]  = '{4'b0100, 32'h00A5_0000, 4'b0100, 1'b0, 2'd2, 8'h00, 1'b1};
        vecs[1]  = '{4'b0100, 32'h00A5_0000, 4'b0000, 1'b1, 2'd2, 8'hA5, 1'b1};
        vecs[2]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 2'd2, 8'hA5, 1'b0};
        vecs[3]  = '{4'b0001, 32'h0000_003C, 4'b0001, 1'b0, 2'd0, 8'hA5, 1'b1};
        vecs[4]  = '{4'b0001, 32'h0000_003C, 4'b0000, 1'b1, 2'd0, 8'h3C, 1'b1};
        vecs[5]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 2'd0, 8'h3C, 1'b0};
        vecs[6]  = '{4'b0010, 32'h0000_EE00, 4'b0010, 1'b0, 2'd1, 8'h3C, 1'b1};
        vecs[7]  = '{4'b0000, 32'h0000_EE00, 4'b0000, 1'b0, 2'd1, 8'h3C, 1'b0};
        vecs[8]  = '{4'b0011, 32'h0000_7781, 4'b0010, 1'b0, 2'd1, 8'h3C, 1'b1};
        vecs[9]  = '{4'b0011, 32'h0000_7781, 4'b0000, 1'b1, 2'd1, 8'h77, 1'b1};
        vecs[10] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 2'd1, 8'h77, 1'b0};

        reset_async = 1'b0;
        step();
        step();
        chk_all("reset", 0, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
        reset_async = 1'b1;

        for (int i = 0; i < 11; i++) begin
            req   = vecs[i].req;
            wdata = vecs[i].wd;
            step();
            chk_all("vec", i, vecs[i].gnt, vecs[i].ack, vecs[i].own, vecs[i].q, vecs[i].busy);
        end

        // reset mid-GRANT: pointer is 2, so req[1] is found after wrapping
        req   = 4'b0010;
        wdata = 32'h0000_5500;
        step();
        chk_all("rst_pre", 0, 4'b0010, 1'b0, 2'd1, 8'h77, 1'b1);
        #3;
        reset_async = 1'b0;
        #1;
        chk_all("rst_async", 0, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
        req = 4'b0000;
        step();
        #2;
        reset_async = 1'b1;
        req = 4'b0010;
        step();
        chk_all("rst_rereq", 0, 4'b0010, 1'b0, 2'd1, 8'h00, 1'b1);
        step();
        chk_all("rst_rereq", 1, 4'b0000, 1'b1, 2'd1, 8'h55, 1'b1);
        req = 4'b0000;
        step();

        // fairness from a freshly reset pointer, all requests held
        reset_async = 1'b0;
        step();
        reset_async = 1'b1;
        req   = 4'b1111;
        wdata = 32'h4433_2211;
        for (int g = 0; g < 5; g++) begin
            waited = 0;
            while (gnt == 4'b0000 && waited < 6) begin
                step();
                waited++;
            end
`ifdef SHARED_REG_ARB_FIXED_PRIO_EN
            expi = 0;
`else
            expi = g % 4;
`endif
            chk("fair.gnt", g, 32'(gnt), 32'(4'b0001 << expi));
            step();
            chk("fair.q", g, 32'(q), 32'(8'h11 * (expi + 1)));
        end
        req = 4'b0000;
        step();
        step();

        // req[3] rises during ACK of requester 0
        reset_async = 1'b0;
        step();
        reset_async = 1'b1;
        wdata = 32'hC700_0009;
        acks  = 0;
        req   = 4'b0001;
        step();
        chk("busy.gnt0", 0, 32'(gnt), 32'(4'b0001));
        step();
        if (ack) acks++;
        req = 4'b1000;
        chk("busy.q0", 0, 32'(q), 32'h09);
        step();
        if (ack) acks++;
        chk_all("busy_idle", 0, 4'b0000, 1'b0, 2'd0, 8'h09, 1'b0);
        step();
        if (ack) acks++;
        chk_all("busy_g3", 0, 4'b1000, 1'b0, 2'd3, 8'h09, 1'b1);
        step();
        if (ack) acks++;
        req = 4'b0000;
        chk("busy.q3", 0, 32'(q), 32'hC7);
        for (gidx = 0; gidx < 4; gidx++) begin
            step();
            if (ack) acks++;
        end
        chk("busy.acks", 0, 32'(acks), 32'd2);
        chk("busy.final", 0, 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
